// File: rtl/router_rx.sv
// router_rx: oversampled serial frame receiver with a WISHBONE-read holding register and rts flow control
module router_rx #(
  parameter int DATA_W = 129,
  parameter int OVS    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic              ack_o,
  input  logic              we_i,
  output logic [DATA_W-1:0] dat_o,
  input  logic              cs_i,
  input  logic              baud16x_ce,
  input  logic              rxd,
  output logic              rts,
  output logic              data_present,
  output logic              overrun,
  output logic              frame_err
);
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVS - 1);
  localparam logic [7:0] LAST = 8'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, TAIL} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d;
  logic sync1_q, rxs_q;
  logic data_present_q, data_present_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic rd, done, start_fail, accept;
  assign ack_o = cyc_i & stb_i & cs_i;
  assign rd = ack_o & ~we_i;
  assign dat_o = hold_q;
  assign rts = ~data_present_q;
  assign data_present = data_present_q;
  assign overrun = overrun_q;
  assign frame_err = frame_err_q;
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    done = 1'b0;
    start_fail = 1'b0;
    if (baud16x_ce) begin
      case (state_q)
        IDLE: if (!rxs_q) begin
          state_d = START;
          tick_d = TW'(1);
        end
        START: if (tick_q == HALF_M1) begin
          state_d = rxs_q ? IDLE : DATA;
          start_fail = rxs_q;
          tick_d = '0;
          bit_d = '0;
        end else tick_d = tick_q + 1'b1;
        DATA: if (tick_q == FULL_M1) begin
          shift_d = {rxs_q, shift_q[DATA_W-1:1]};
          tick_d = '0;
          done = (bit_q == LAST);
          bit_d = done ? 8'd0 : bit_q + 8'd1;
          state_d = done ? TAIL : DATA;
        end else tick_d = tick_q + 1'b1;
        default: if (tick_q == HALF_M1) begin
          // TAIL ends on the last bit boundary so a low final bit never looks like a start
          state_d = IDLE;
          tick_d = '0;
        end else tick_d = tick_q + 1'b1;
      endcase
    end
    accept = done & (~data_present_q | rd);
    hold_d = accept ? shift_d : hold_q;
    data_present_d = accept | (data_present_q & ~rd);
    overrun_d = (done & ~accept) | (overrun_q & ~rd);
    frame_err_d = start_fail | (frame_err_q & ~rd);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      data_present_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs_q <= sync1_q;
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      data_present_q <= data_present_d;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_router_rx.sv
// tb_router_rx: scoreboard bench driving serial frames into router_rx and reading them back over the bus
module tb_router_rx;
  localparam int DATA_W = 129;
  localparam int OVS = 16;
  localparam int FRAME = OVS * (DATA_W + 1);
  logic clk = 1'b0;
  logic rst_i = 1'b1, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, cs_i = 1'b0;
  logic baud16x_ce = 1'b1, rxd = 1'b1;
  logic ack_o, rts, data_present, overrun, frame_err;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] exp_q[$];
  int total = 0, bad = 0;
  router_rx #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o), .we_i(we_i),
    .dat_o(dat_o), .cs_i(cs_i), .baud16x_ce(baud16x_ce), .rxd(rxd), .rts(rts),
    .data_present(data_present), .overrun(overrun), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [DATA_W-1:0] pop_exp();
    return exp_q.size() != 0 ? exp_q.pop_front() : {DATA_W{1'bx}};
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask
  task automatic send(input logic [DATA_W-1:0] d, input bit push, input int rd_at, input int rst_at);
    if (push) exp_q.push_back(d);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_i = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        return;
      end
      rxd = (c < OVS) ? 1'b0 : d[c/OVS-1];
      if (rd_at >= 0 && c == rd_at + 1) {cyc_i, stb_i, cs_i} = 3'b000;
      if (c == rd_at) begin
        {cyc_i, stb_i, cs_i, we_i} = 4'b1110;
        #1 chk("rd_on_done", dat_o, pop_exp());
      end
    end
  endtask
  task automatic wait_dp();
    int n = 0;
    while (!data_present && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("dp_set", data_present, 1);
    chk("rts_low", rts, 0);
  endtask
  task automatic bus_read(input string tag);
    @(negedge clk);
    rxd = 1'b1;
    {cyc_i, stb_i, cs_i, we_i} = 4'b1110;
    #1 chk("rd_ack", ack_o, 1);
    chk(tag, dat_o, pop_exp());
    @(negedge clk);
    {cyc_i, stb_i, cs_i} = 3'b000;
  endtask
  task automatic bus_write();
    @(negedge clk);
    {cyc_i, stb_i, cs_i, we_i} = 4'b1111;
    #1 chk("wr_ack", ack_o, 1);
    @(negedge clk);
    {cyc_i, stb_i, cs_i, we_i} = 4'b0000;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    logic [DATA_W-1:0] d1, fa, f1, f2;
    d1 = 129'h1_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    fa = 129'h0_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    f1 = 129'h0_DEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
    f2 = 129'h1_5555_AAAA_3C3C_C3C3_0F0F_F0F0_1234_8765;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    idle(1000);
    chk("rst_dp", data_present, 0);
    chk("rst_rts", rts, 1);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_dat", dat_o, 0);
    send(d1, 1, -1, -1);
    wait_dp();
    idle(20);
    bus_write();
    chk("wr_no_effect", data_present, 1);
    bus_read("rd_d1");
    chk("rd_clr_dp", data_present, 0);
    chk("rd_rts", rts, 1);
    send(fa, 1, -1, -1);
    send('0, 0, -1, -1);
    idle(20);
    chk("b2b_dp", data_present, 1);
    chk("b2b_ovr", overrun, 1);
    bus_read("rd_first");
    chk("b2b_clr_dp", data_present, 0);
    chk("b2b_clr_ovr", overrun, 0);
    repeat (5) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    idle(30);
    chk("glitch_ferr", frame_err, 1);
    chk("glitch_dp", data_present, 0);
    send(129'h1, 1, -1, -1);
    wait_dp();
    idle(20);
    bus_read("rd_one");
    chk("ferr_clr", frame_err, 0);
    send(f1, 1, -1, -1);
    send(f2, 1, 2073, -1);
    idle(20);
    chk("race_dp", data_present, 1);
    chk("race_ovr", overrun, 0);
    bus_read("rd_f2");
    chk("race_clr_dp", data_present, 0);
    send({DATA_W{1'b1}} ^ d1, 0, -1, OVS * 61 + 8);
    idle(40);
    chk("abort_dp", data_present, 0);
    chk("abort_ferr", frame_err, 0);
    chk("abort_ovr", overrun, 0);
    chk("abort_dat", dat_o, 0);
    send(129'h1F, 1, -1, -1);
    wait_dp();
    idle(20);
    bus_read("rd_1f");
    chk("end_ovr", overrun, 0);
    chk("end_ferr", frame_err, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_rx.md
Name: router_rx

Overview:
- Serial receiver for the router link: the far end of the router transmitter.
- Recovers frames from `rxd` using the shared 16x baud clock enable. A frame is one start bit (0) followed by DATA_W data bits, LSB first, with no mandatory stop bit; back-to-back frames are legal.
- Delivers each frame into a single holding register, read over the WISHBONE SoC bus.
- Drives `rts` back to the transmitter's `cts`, so a new frame is only requested when the holding register is free.

Parameters:
- DATA_W, 129, data bits per frame.
- OVS, 16, baud16x_ce ticks per bit; must be a power of 2, at least 4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cyc_i  in  1  WISHBONE cycle valid
- stb_i  in  1  WISHBONE strobe
- ack_o  out  1  transfer done; combinational cyc_i & stb_i & cs_i
- we_i  in  1  write enable; writes are acked and ignored
- dat_o  out  DATA_W  holding register contents
- cs_i  in  1  chip select
- baud16x_ce  in  1  oversample clock enable
- rxd  in  1  external serial input, asynchronous
- rts  out  1  ready to send; equals ~data_present
- data_present  out  1  holding register full
- overrun  out  1  sticky: a frame was dropped because the holding register was full
- frame_err  out  1  sticky: start bit failed validation at its mid-bit sample

Behaviour:
- Reset values:
  - data_present=0, overrun=0, frame_err=0, rts=1.
  - dat_o=0, state=IDLE, all counters 0.
  - Both synchronizer flops = 1.
  - Reset mid-frame abandons the frame with no holding-register update.
- Synchronizer: `rxd` passes through 2 flops every clk_i. All decisions use the second flop (rxs). Latency from rxd to rxs is 2 clocks.
- Timing: all state and counter activity advances only on cycles with baud16x_ce=1; bus and status logic run every clk_i.
- Counters:
  - tick counter: log2(OVS) bits.
  - bit counter: 8 bits, counts 0..DATA_W-1.
  - shift register: DATA_W bits; each sampled bit enters at the MSB and shifts right, so bit 0 ends at LSB after DATA_W samples.
- State machine:
  - IDLE: on a ce with rxs=0, go to START with tick=1.
  - START: on the ce where tick reaches OVS/2-1 (mid start bit):
    - rxs=0 -> DATA, tick=0, bit=0.
    - rxs=1 -> IDLE and set frame_err.
  - DATA: when tick = OVS-1, sample rxs into the shift register, set tick=0, and increment bit.
  - Completion: on the sample where bit = DATA_W-1, the completion event fires and the state goes to TAIL.
  - TAIL: wait OVS/2 ce ticks (to the end of the last data bit), then go to IDLE. A 0 last data bit is never mistaken for a start bit.
- Completion event (single cycle):
  - data_present=0, or a bus read in the same cycle -> holding register := shift register value including the final bit; data_present=1.
  - data_present=1 and no read that cycle -> new frame discarded, holding register unchanged, overrun=1.
- Bus read = ack_o & ~we_i:
  - Clears data_present, overrun and frame_err on the next edge.
  - dat_o is the holding value during the ack cycle.
  - Read and completion in the same cycle: data_present ends at 1 with the new data; overrun stays 0.
- Bus write: acked, no effect.
- Frame duration is OVS*(1+DATA_W) ticks.
  - Sampling must tolerate the next start bit beginning exactly at tick OVS*(1+DATA_W) after the previous falling edge.
  - Because TAIL ends at the last bit boundary, the next start bit is detected within 1 ce tick after TAIL exits to IDLE.
- A glitch on rxd shorter than OVS/2 ticks while in IDLE is rejected, with frame_err set.

Test Plan:
- Reset, then idle line high for 1000 ce -> data_present=0, rts=1, overrun=0, frame_err=0, dat_o=0.
- Transmit frame with data = 129'h1_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, OVS=16, ce every clock -> data_present=1 and rts=0 within 16*130+4 clocks of the falling edge; bus read returns that value and data_present clears the next clock.
- Two back-to-back frames, the first ending in data bit 128=0 and the second = 129'h0 with no idle gap, no read in between -> holding register = first frame, overrun=1; a subsequent read clears both flags.
- 5-tick low pulse on rxd while idle -> frame_err=1, data_present=0. Then a valid frame 129'h1 -> received correctly.
- Read asserted exactly on the completion cycle of the second frame -> read returns frame 1, holding register = frame 2, data_present=1, overrun=0.
- rst_i asserted for 1 cycle at data bit 60 of a frame, then a clean frame 129'h1F -> only 129'h1F received; no flag set from the aborted frame.
